// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front end of the accumulator CPU.
//   Owns the program counter, the instruction RAM port and the fetch-to-decode
//   stage register. It runs a program-load phase (words streamed into RAM from
//   address 0), then a fetch loop: FETCH issues the read, CAPT registers the
//   returned word, and HOLD presents it to decode with a valid/ready handshake.
//   Execute may redirect the PC on the accept cycle. A HALT opcode ends the loop.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   start, ld_start    pulses: begin fetch at PC 0 / begin load at address 0
//   ld_valid/last/data load stream in; ld_ready out (high only in LOAD)
//   ram_*              instruction RAM control; ram_rdata valid one cycle after read
//   instr_valid/ready  handshake to decode; instr_out word, instr_pc = its PC+1
//   br_valid/target    PC redirect, honoured only on the HOLD accept cycle
//   busy, halted       status
//
// Optional build macro FETCH_STATS_EN adds retired_cnt, a saturating count of
// accepted instructions, cleared by reset and by an accepted start pulse.

module fetch_sequencer #(
    parameter int         AW      = 8,
    parameter int         IW      = 16,
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic          ld_last,
    input  logic [IW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ram_en,
    output logic          ram_rd_en,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_addr,
    output logic [IW-1:0] ram_wdata,
    input  logic [IW-1:0] ram_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] instr_pc,
    input  logic          br_valid,
    input  logic [AW-1:0] br_target,
    output logic          busy,
    output logic          halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]   retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_CAPT, S_HOLD, S_HALT
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] pc, ld_cnt;
    logic          accept, is_halt, ld_end, start_go;

    assign instr_valid = (state == S_HOLD);
    assign accept      = instr_valid & instr_ready;
    assign is_halt     = (instr_out[IW-1:IW-5] == HALT_OP);
    // A load ends on the flagged word or on the last RAM address.
    assign ld_end      = ld_last | (ld_cnt == {AW{1'b1}});
    // ld_start has priority over start in IDLE and HALT.
    assign start_go    = ((state == S_IDLE) || (state == S_HALT)) && start && !ld_start;
    assign busy        = (state != S_IDLE) && (state != S_HALT);
    assign halted      = (state == S_HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        ld_ready  = 1'b0;
        ram_en    = 1'b0;
        ram_rd_en = 1'b0;
        ram_wr_en = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (ld_start)   state_nx = S_LOAD;
                else if (start) state_nx = S_FETCH;
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ram_en    = 1'b1;
                    ram_wr_en = 1'b1;
                    ram_addr  = ld_cnt;
                    ram_wdata = ld_data;
                    if (ld_end) state_nx = S_IDLE;
                end
            end
            S_FETCH: begin
                ram_en    = 1'b1;
                ram_rd_en = 1'b1;
                ram_addr  = pc;
                state_nx  = S_CAPT;
            end
            S_CAPT: state_nx = S_HOLD;
            S_HOLD: begin
                if (accept) state_nx = is_halt ? S_HALT : S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            ld_cnt    <= '0;
            instr_out <= '0;
            instr_pc  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start_go) pc <= '0;
                end
                S_LOAD: begin
                    if (ld_valid) ld_cnt <= ld_end ? '0 : ld_cnt + 1'b1;
                end
                S_CAPT: begin
                    instr_out <= ram_rdata;
                    instr_pc  <= pc + 1'b1;
                    pc        <= pc + 1'b1;
                end
                S_HOLD: begin
                    // A HALT word ignores any redirect on its accept cycle.
                    if (accept && !is_halt && br_valid) pc <= br_target;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       retired_cnt <= '0;
        else if (start_go)                retired_cnt <= '0;
        else if (accept && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_ready, ram_en, ram_rd_en, ram_wr_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        instr_valid, instr_ready = 1'b0;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic        br_valid = 1'b0;
    logic [7:0]  br_target = '0;
    logic        busy, halted;
`ifdef FETCH_STATS_EN
    logic [15:0] retired_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic init_mem = 1'b1;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ld_start(ld_start),
        .ld_valid(ld_valid), .ld_last(ld_last), .ld_data(ld_data), .ld_ready(ld_ready),
        .ram_en(ram_en), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .br_valid(br_valid), .br_target(br_target),
        .busy(busy), .halted(halted)
`ifdef FETCH_STATS_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Bench-owned instruction RAM with one-cycle read latency.
    logic [15:0] tb_mem [256];
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
            ram_rdata <= '0;
        end else begin
            if (ram_en && ram_wr_en) tb_mem[ram_addr] <= ram_wdata;
            if (ram_en && ram_rd_en) ram_rdata <= tb_mem[ram_addr];
        end
    end

    // Behavioural model: loading flag + write pointer, and a fetch "age"
    // (-1 none, 0 read issued, 1 word returning, 2 presented to decode).
    bit          m_load, m_halt;
    int          m_age;
    logic [7:0]  m_waddr, m_pc, m_ipc;
    logic [15:0] m_iout;
    logic [15:0] m_mem [256];
`ifdef FETCH_STATS_EN
    logic [15:0] m_ret;
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_load <= 0; m_halt <= 0; m_age <= -1;
            m_waddr <= 0; m_pc <= 0; m_ipc <= 0; m_iout <= 0;
`ifdef FETCH_STATS_EN
            m_ret <= 0;
`endif
            if (init_mem) for (int i = 0; i < 256; i++) m_mem[i] <= '0;
        end else if (m_load) begin
            if (ld_valid) begin
                m_mem[m_waddr] <= ld_data;
                if (ld_last || m_waddr == 8'hFF) begin m_load <= 0; m_waddr <= 0; end
                else m_waddr <= m_waddr + 8'd1;
            end
        end else if (m_age == 0) begin
            m_age <= 1;
        end else if (m_age == 1) begin
            m_iout <= m_mem[m_pc];
            m_ipc  <= m_pc + 8'd1;
            m_pc   <= m_pc + 8'd1;
            m_age  <= 2;
        end else if (m_age == 2) begin
            if (instr_ready) begin
`ifdef FETCH_STATS_EN
                if (m_ret != 16'hFFFF) m_ret <= m_ret + 16'd1;
`endif
                if (m_iout[15:11] == 5'h1F) begin m_age <= -1; m_halt <= 1; end
                else begin
                    m_age <= 0;
                    if (br_valid) m_pc <= br_target;
                end
            end
        end else begin
            if (ld_start) begin m_load <= 1; m_halt <= 0; end
            else if (start) begin
                m_pc <= 0; m_age <= 0; m_halt <= 0;
`ifdef FETCH_STATS_EN
                m_ret <= 0;
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ld_ready", 32'(ld_ready), 32'(m_load));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(m_load && ld_valid));
        chk("ram_rd_en", 32'(ram_rd_en), 32'(m_age == 0));
        chk("ram_en", 32'(ram_en), 32'((m_load && ld_valid) || m_age == 0));
        if (m_load && ld_valid) begin
            chk("wr_addr", 32'(ram_addr), 32'(m_waddr));
            chk("wr_data", 32'(ram_wdata), 32'(ld_data));
        end
        if (m_age == 0) chk("rd_addr", 32'(ram_addr), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(m_age == 2));
        chk("instr_out", 32'(instr_out), 32'(m_iout));
        chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
        chk("busy", 32'(busy), 32'(m_load || m_age >= 0));
        chk("halted", 32'(halted), 32'(m_halt));
`ifdef FETCH_STATS_EN
        chk("retired_cnt", 32'(retired_cnt), 32'(m_ret));
`endif
    end

    // Log of accepted instructions.
    logic [15:0] acc_q[$];
    logic [7:0]  pc_q[$];
    always @(negedge clk) begin
        if (reset && instr_valid && instr_ready) begin
            acc_q.push_back(instr_out);
            pc_q.push_back(instr_pc);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        chk(nm, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_halt(input string nm);
        int n = 0;
        while (!halted && n < 60) begin tick(); n++; end
        chk(nm, 32'(halted), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_instr_out", 32'(instr_out), 32'd0);
        init_mem = 1'b0;
        reset = 1'b1;
        tick();

        // Load three words
        ld_start = 1; tick(); ld_start = 0;
        ld_valid = 1; ld_data = 16'h0801; tick();
        ld_data = 16'h1002; tick();
        ld_data = 16'hF800; ld_last = 1; tick();
        ld_valid = 0; ld_last = 0; tick();
        chk("load_exit_ld_ready", 32'(ld_ready), 32'd0);
        chk("load_exit_busy", 32'(busy), 32'd0);
        chk("mem0", 32'(tb_mem[0]), 32'h0801);
        chk("mem1", 32'(tb_mem[1]), 32'h1002);
        chk("mem2", 32'(tb_mem[2]), 32'hF800);

        // Fetch loop with ready held
        acc_q.delete(); pc_q.delete();
        instr_ready = 1; start = 1; tick(); start = 0;
        wait_halt("fetch_halt_timeout");
        chk("acc_count", 32'(acc_q.size()), 32'd3);
        if (acc_q.size() == 3) begin
            chk("acc0", 32'(acc_q[0]), 32'h0801);
            chk("acc1", 32'(acc_q[1]), 32'h1002);
            chk("acc2", 32'(acc_q[2]), 32'hF800);
            chk("acc_pc0", 32'(pc_q[0]), 32'd1);
            chk("acc_pc1", 32'(pc_q[1]), 32'd2);
            chk("acc_pc2", 32'(pc_q[2]), 32'd3);
        end
`ifdef FETCH_STATS_EN
        chk("retired3", 32'(retired_cnt), 32'd3);
`endif
        instr_ready = 0;

        // Backpressure on address 0
        start = 1; tick(); start = 0;
        wait_valid("bp_valid_timeout");
        repeat (5) tick();
        chk("bp_valid", 32'(instr_valid), 32'd1);
        chk("bp_out", 32'(instr_out), 32'h0801);
        chk("bp_pc", 32'(instr_pc), 32'd1);
        instr_ready = 1; tick(); instr_ready = 0;
        chk("bp_next_rd", 32'(ram_rd_en), 32'd1);
        chk("bp_next_addr", 32'(ram_addr), 32'd1);

        // Redirect without accept is ignored
        wait_valid("nb_valid_timeout");
        br_valid = 1; br_target = 8'h20; tick(); tick();
        br_valid = 0; instr_ready = 1; tick();
        chk("nb_next_addr", 32'(ram_addr), 32'd2);
        wait_halt("nb_halt_timeout");
        instr_ready = 0;

        // Redirect on accept of address 0
        start = 1; tick(); start = 0;
        wait_valid("br_valid_timeout");
        br_valid = 1; br_target = 8'h40; instr_ready = 1; tick();
        br_valid = 0; instr_ready = 0;
        chk("br_rd", 32'(ram_rd_en), 32'd1);
        chk("br_addr", 32'(ram_addr), 32'h40);
        wait_valid("br2_valid_timeout");
        chk("br_instr_pc", 32'(instr_pc), 32'h41);

        // Asynchronous reset in HOLD
        #3 reset = 0;
        #1;
        chk("rh_valid", 32'(instr_valid), 32'd0);
        chk("rh_busy", 32'(busy), 32'd0);
        chk("rh_out", 32'(instr_out), 32'd0);
        chk("rh_pc", 32'(instr_pc), 32'd0);
        tick(); tick();
        reset = 1; tick();
        instr_ready = 1; start = 1; tick(); start = 0;
        chk("rh_restart_addr", 32'(ram_addr), 32'd0);
        chk("rh_restart_rd", 32'(ram_rd_en), 32'd1);
        wait_halt("rh_halt_timeout");
        instr_ready = 0;

        // Asynchronous reset in LOAD
        ld_start = 1; tick(); ld_start = 0;
        ld_valid = 1; ld_data = 16'hAAAA; tick();
        ld_data = 16'hBBBB;
        #3 reset = 0;
        #1;
        chk("rl_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rl_ld_ready", 32'(ld_ready), 32'd0);
        tick();
        ld_valid = 0; reset = 1; tick();
        chk("rl_mem0", 32'(tb_mem[0]), 32'hAAAA);
        chk("rl_mem1", 32'(tb_mem[1]), 32'h1002);

        // Full 256-word load with no ld_last
        ld_start = 1; tick(); ld_start = 0;
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1;
            ld_data = (i == 0) ? 16'h0800 : (i == 1) ? 16'hF800 :
                      (i == 255) ? 16'h1234 : (16'h0800 | 16'(i));
            tick();
        end
        ld_data = 16'h5555;
        chk("full_exit_ld_ready", 32'(ld_ready), 32'd0);
        chk("full_exit_busy", 32'(busy), 32'd0);
        tick();
        ld_valid = 0;
        chk("full_mem0", 32'(tb_mem[0]), 32'h0800);
        chk("full_memff", 32'(tb_mem[255]), 32'h1234);

        // PC wrap from 0xFF
        start = 1; tick(); start = 0;
        wait_valid("wrap_valid_timeout");
        chk("wrap_first", 32'(instr_out), 32'h0800);
        br_valid = 1; br_target = 8'hFF; instr_ready = 1; tick();
        br_valid = 0; instr_ready = 0;
        chk("wrap_ff_addr", 32'(ram_addr), 32'hFF);
        wait_valid("wrap2_valid_timeout");
        chk("wrap_ff_word", 32'(instr_out), 32'h1234);
        chk("wrap_ff_pc", 32'(instr_pc), 32'h00);
        instr_ready = 1; tick();
        chk("wrap_next_rd", 32'(ram_rd_en), 32'd1);
        chk("wrap_next_addr", 32'(ram_addr), 32'h00);
        wait_halt("wrap_halt_timeout");
        instr_ready = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
